// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM state type and control-vector layout for the alu_seq command sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_CLR = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;
  localparam logic [3:0] OP_SHR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_ROR = 4'h7;

  // Any op with this bit set routes alu_f into the register.
  localparam int unsigned OP_ALU_BIT = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic cl;
    logic ld;
    logic inc;
    logic dec;
    logic sr;
    logic ir;
    logic sl;
    logic il;
  } ctl_t;

  // INC..ROR use imm as a repeat count rather than as operand data.
  function automatic logic is_repeat_op(input logic [3:0] op);
    return !op[OP_ALU_BIT] && (op >= OP_INC) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/alu_seq_dec.sv
// Combinational decoder: latched opcode plus register/ALU data to register control vector and load data.
module alu_seq_dec
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] imm,
  input  logic          reg_out_lsb,
  input  logic [DW-1:0] alu_f,
  output ctl_t          ctl,
  output logic [DW-1:0] reg_in
);

  always_comb begin
    ctl    = '0;
    reg_in = '0;
    if (op[OP_ALU_BIT]) begin
      ctl.ld = 1'b1;
      reg_in = alu_f;
    end else begin
      case (op)
        OP_CLR: ctl.cl = 1'b1;
        OP_LDI: begin
          ctl.ld = 1'b1;
          reg_in = imm;
        end
        OP_INC: ctl.inc = 1'b1;
        OP_DEC: ctl.dec = 1'b1;
        OP_SHR: ctl.sr  = 1'b1;
        OP_SHL: ctl.sl  = 1'b1;
        // Rotate: feed the bit about to fall off back in at the top.
        OP_ROR: begin
          ctl.sr = 1'b1;
          ctl.ir = reg_out_lsb;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Instruction sequencer driving a 4-bit register and ALU over cmd/rsp valid-ready channels.
// Optional ALU_SEQ_STATS_EN adds a 16-bit count of completed responses (cmd_count).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [2:0]    alu_oc,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_f,
  output logic          reg_cl,
  output logic          reg_ld,
  output logic          reg_inc,
  output logic          reg_dec,
  output logic          reg_sr,
  output logic          reg_ir,
  output logic          reg_sl,
  output logic          reg_il,
  output logic [DW-1:0] reg_in,
  input  logic [DW-1:0] reg_out
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]   cmd_count
`endif
);

  state_t        state, state_nxt;
  logic [3:0]    rep, rep_nxt;
  logic [7:0]    instr, instr_nxt;
  logic          exec;
  logic [DW-1:0] imm_q;
  ctl_t          dec_ctl, ctl;
  logic [DW-1:0] dec_reg_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rep   <= '0;
      instr <= '0;
    end else begin
      state <= state_nxt;
      rep   <= rep_nxt;
      instr <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rep_nxt   = rep;
    instr_nxt = instr;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    exec      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          instr_nxt = cmd_data;
          rep_nxt   = is_repeat_op(cmd_data[7:4]) ? cmd_data[3:0] : 4'd0;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        exec = 1'b1;
        if (rep == 4'd0) state_nxt = RESP;
        else             rep_nxt   = rep - 4'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imm_q = DW'(instr[3:0]);

  alu_seq_dec #(
    .DW(DW)
  ) u_dec (
    .op          (instr[7:4]),
    .imm         (imm_q),
    .reg_out_lsb (reg_out[0]),
    .alu_f       (alu_f),
    .ctl         (dec_ctl),
    .reg_in      (dec_reg_in)
  );

  // Gating with rst keeps the register from taking a pulse on the edge that aborts EXEC.
  assign ctl    = (exec && !rst) ? dec_ctl    : '0;
  assign reg_in = (exec && !rst) ? dec_reg_in : '0;

  assign reg_cl  = ctl.cl;
  assign reg_ld  = ctl.ld;
  assign reg_inc = ctl.inc;
  assign reg_dec = ctl.dec;
  assign reg_sr  = ctl.sr;
  assign reg_ir  = ctl.ir;
  assign reg_sl  = ctl.sl;
  assign reg_il  = ctl.il;

  assign alu_oc   = instr[6:4];
  assign alu_a    = reg_out;
  assign alu_b    = imm_q;
  assign rsp_data = reg_out;

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                         cmd_count <= '0;
    else if (rsp_valid && rsp_ready) cmd_count <= cmd_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with an environment register/ALU and an arithmetic result model.
module tb_alu_seq;

  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [7:0]    cmd_data;
  logic [DW-1:0] rsp_data, alu_a, alu_b, alu_f, reg_in, reg_out;
  logic [2:0]    alu_oc;
  logic          reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]   cmd_count;
`endif

  int            errors = 0;
  int            checks = 0;
  int unsigned   n_rsp  = 0;
  logic [3:0]    reg_q  = '0;

  always #5 clk = ~clk;

  alu_seq #(
    .DW(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_oc    (alu_oc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .reg_cl    (reg_cl),
    .reg_ld    (reg_ld),
    .reg_inc   (reg_inc),
    .reg_dec   (reg_dec),
    .reg_sr    (reg_sr),
    .reg_ir    (reg_ir),
    .reg_sl    (reg_sl),
    .reg_il    (reg_il),
    .reg_in    (reg_in),
    .reg_out   (reg_out)
`ifdef ALU_SEQ_STATS_EN
    ,
    .cmd_count (cmd_count)
`endif
  );

  // Environment: the downstream register and an arbitrary 8-function ALU.
  function automatic logic [3:0] alu_fn(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
    case (oc)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return b;
      default: return a;
    endcase
  endfunction

  assign alu_f   = alu_fn(alu_oc, alu_a, alu_b);
  assign reg_out = reg_q;

  always @(posedge clk) begin
    if (reg_cl)       reg_q <= '0;
    else if (reg_ld)  reg_q <= reg_in;
    else if (reg_inc) reg_q <= reg_q + 4'd1;
    else if (reg_dec) reg_q <= reg_q - 4'd1;
    else if (reg_sr)  reg_q <= {reg_ir, reg_q[3:1]};
    else if (reg_sl)  reg_q <= {reg_q[2:0], reg_il};
  end

  // Whole-instruction result from plain arithmetic on the starting register value.
  function automatic logic [3:0] expect_val(input logic [7:0] d, input logic [3:0] r);
    int n, k, v;
    n = int'(d[3:0]) + 1;
    case (d[7:4])
      4'h0: v = int'(r);
      4'h1: v = 0;
      4'h2: v = int'(d[3:0]);
      4'h3: v = int'(r) + n;
      4'h4: v = int'(r) + 64 - n;
      4'h5: v = int'(r) >> n;
      4'h6: v = int'(r) << n;
      4'h7: begin
        k = n % 4;
        v = (int'(r) >> k) | (int'(r) << (4 - k));
      end
      default: v = int'(alu_fn(d[6:4], r, d[3:0]));
    endcase
    return 4'(v);
  endfunction

  // Expected {cl, ld, inc, dec, sr, sl} for one EXEC cycle.
  function automatic logic [5:0] ctl_of(input logic [3:0] op);
    if (op[3]) return 6'b010000;
    case (op)
      4'h1:        return 6'b100000;
      4'h2:        return 6'b010000;
      4'h3:        return 6'b001000;
      4'h4:        return 6'b000100;
      4'h5, 4'h7:  return 6'b000010;
      4'h6:        return 6'b000001;
      default:     return 6'b000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};
  endfunction

  task automatic run_cmd(input logic [7:0] d, input int unsigned hold);
    logic [3:0]  op, imm, exp_val;
    logic [5:0]  exp_ctl;
    int unsigned exp_len, len;
    op      = d[7:4];
    imm     = d[3:0];
    exp_len = (op >= 4'h3 && op <= 4'h7) ? int'(imm) + 1 : 1;
    exp_ctl = ctl_of(op);
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    exp_val   = expect_val(d, reg_q);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    len = 0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      len++;
      check("exec_ctl", 32'(ctl_now()), 32'(exp_ctl));
      check("exec_cmd_ready", 32'(cmd_ready), 0);
      check("exec_alu_oc", 32'(alu_oc), 32'(op[2:0]));
      check("exec_alu_b", 32'(alu_b), 32'(imm));
      check("exec_alu_a", 32'(alu_a), 32'(reg_q));
      if (op == 4'h2) check("ldi_reg_in", 32'(reg_in), 32'(imm));
      if (op[3])      check("alu_reg_in", 32'(reg_in), 32'(alu_fn(op[2:0], reg_q, imm)));
      if (op == 4'h5) check("shr_reg_ir", 32'(reg_ir), 0);
      if (op == 4'h7) check("ror_reg_ir", 32'(reg_ir), 32'(reg_q[0]));
      if (op == 4'h6) check("shl_reg_il", 32'(reg_il), 0);
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("exec_len", len, exp_len);
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_data", 32'(rsp_data), 32'(exp_val));
    check("resp_ctl", 32'({ctl_now(), reg_ir, reg_il}), 0);
    for (int unsigned i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_data  = 8'($urandom);
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 1);
      check("hold_rsp_data", 32'(rsp_data), 32'(exp_val));
      check("hold_cmd_ready", 32'(cmd_ready), 0);
      check("hold_ctl", 32'(ctl_now()), 0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    n_rsp++;
    check("after_rsp_valid_ready", 32'({rsp_valid, cmd_ready}), 32'b01);
`ifdef ALU_SEQ_STATS_EN
    check("cmd_count", 32'(cmd_count), 32'(n_rsp & 32'hFFFF));
`endif
  endtask

  initial begin
    logic [3:0] r0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_ctl", 32'({ctl_now(), reg_ir, reg_il}), 0);
    check("rst_reg_in", 32'(reg_in), 0);
    check("rst_alu_oc", 32'(alu_oc), 0);
    check("rst_alu_b", 32'(alu_b), 0);
`ifdef ALU_SEQ_STATS_EN
    check("rst_cmd_count", 32'(cmd_count), 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Directed walk: LDI 5, INC x3, SHR, LDI 5, ROR, ALU with backpressure.
    run_cmd(8'h25, 0);
    check("ldi_value", 32'(reg_q), 5);
    run_cmd(8'h32, 0);
    check("inc_value", 32'(reg_q), 8);
    run_cmd(8'h50, 0);
    check("shr_value", 32'(reg_q), 4);
    run_cmd(8'h25, 0);
    run_cmd(8'h70, 0);
    check("ror_value", 32'(reg_q), 32'hA);
    run_cmd(8'hB3, 3);
    run_cmd(8'h00, 1);
    run_cmd(8'h00, 0);
    run_cmd(8'h00, 2);
`ifdef ALU_SEQ_STATS_EN
    check("three_nop_base_count", 32'(cmd_count), 32'(n_rsp));
`endif

    // INC 15 aborted by reset in the 4th EXEC cycle.
    run_cmd(8'h21, 0);
    r0        = reg_q;
    cmd_valid = 1'b1;
    cmd_data  = 8'h3F;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_inc_pulse", 32'(ctl_now()), 32'b001000);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("abort_ctl_in_rst", 32'(ctl_now()), 0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ctl_after", 32'({ctl_now(), reg_ir, reg_il}), 0);
    check("abort_reg_in", 32'(reg_in), 0);
    check("abort_partial", 32'(reg_q), 32'(4'(r0 + 4'd3)));
    check("abort_alu_oc_b", 32'({alu_oc, alu_b}), 0);
    n_rsp = 0;
`ifdef ALU_SEQ_STATS_EN
    check("abort_cmd_count", 32'(cmd_count), 0);
`endif
    for (int i = 0; i < 3; i++) begin
      check("abort_no_rsp", 32'({rsp_valid, cmd_ready}), 32'b01);
      @(negedge clk);
    end

    run_cmd(8'h00, 0);
    run_cmd(8'h00, 0);
    run_cmd(8'h00, 0);
`ifdef ALU_SEQ_STATS_EN
    check("three_nops", 32'(cmd_count), 3);
`endif

    for (int i = 0; i < 40; i++) run_cmd(8'($urandom), $urandom_range(0, 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
